// File: rtl/fetch_defs.sv
// Shared fetch-side definitions: next-PC select codes, fetch FSM state codes
// and architectural constants, common to the fetch unit and the control unit.
package fetch_defs;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_ISSUE = 2'b01,
    S_FAULT = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Instruction words are 4-byte aligned; only the two low address bits matter.
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and the
// instruction memory (slave). Read data is qualified by mem_ack in the same cycle.
interface instruction_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection with word-alignment check of the result.
module next_pc_calc
  import fetch_defs::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  PC_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc + INSTR_BYTES;
    case (pc_sel_e'(PC_sel))
      PC_PLUS4:  next_pc = pc + INSTR_BYTES;
      PC_BRANCH: next_pc = branch_target;
      // JALR clears bit 0 of the computed target before use.
      PC_JALR:   next_pc = jalr_target & ~32'h0000_0001;
      PC_HOLD:   next_pc = pc;
      default:   next_pc = pc + INSTR_BYTES;
    endcase
    misaligned = !word_aligned(next_pc[1:0]);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at pc, presents it to the control
// unit until it is consumed, then selects the next pc; misalignment or a
// memory timeout parks the unit in a sticky fault state until reset.
module instruction_fetch
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master mem,
  output logic [31:0]         instruction,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  input  logic                instr_done,
  input  logic                stall,
  input  logic [1:0]          PC_sel,
  input  logic [31:0]         branch_target,
  input  logic [31:0]         jalr_target,
  output logic                fault,
  output logic [31:0]         fault_pc
);

  localparam int unsigned     CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic             run;
  logic             fetching;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      next_pc;
  logic             misaligned;
  logic             accept;
  logic             expire;
  logic             advance;

  next_pc_calc u_next_pc (
    .pc            (pc),
    .PC_sel        (PC_sel),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  assign accept  = fetching && mem.mem_ack;
  assign expire  = fetching && !mem.mem_ack && (wait_cnt == CNT_LAST);
  assign advance = (state == S_ISSUE) && instr_done && !stall
                   && (pc_sel_e'(PC_sel) != PC_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (accept) begin
          state_nxt = S_ISSUE;
        end else if (expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (advance) begin
          state_nxt = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_REQ;
    endcase
  end

  // run holds the request off until the first clock edge after reset release.
  always_comb begin
    fetching    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      S_REQ:   fetching    = run;
      S_ISSUE: instr_valid = 1'b1;
      S_FAULT: fault       = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req  = fetching;
  assign mem.mem_addr = pc;
  assign pc_plus4     = pc + INSTR_BYTES;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      fault_pc    <= 32'h0000_0000;
      wait_cnt    <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_REQ: begin
          if (accept) begin
            instruction <= mem.mem_rdata;
            wait_cnt    <= '0;
          end else if (expire) begin
            fault_pc <= pc;
          end else if (fetching) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (advance) begin
            if (misaligned) begin
              fault_pc <= next_pc;
            end else begin
              pc       <= next_pc;
              wait_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles mem_req waits for mem_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 mem_addr  output  32  SHALL be the byte address of the requested word.
REQ-007 mem_ack  input  1  SHALL be the memory acknowledge; mem_rdata is valid in the same cycle.
REQ-008 mem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-009 instruction  output  32  SHALL be the registered instruction presented to UnidadDeControl.
REQ-010 instr_valid  output  1  SHALL mark instruction as valid for execution.
REQ-011 pc / pc_plus4  output  32 each  SHALL be the address of the current instruction and that address + 4.
REQ-012 instr_done  input  1  SHALL signal that the consumer has finished the current instruction and that PC_sel and the targets are valid.
REQ-013 stall  input  1  SHALL block PC advance while high.
REQ-014 PC_sel  input  2  SHALL be the next-PC select from the control unit.
REQ-015 branch_target / jalr_target  input  32 each  SHALL be the candidate next-PC addresses.
REQ-016 fault  output  1  SHALL be the sticky misalignment/timeout flag.
REQ-017 fault_pc  output  32  SHALL hold the offending address.

Function
REQ-018 The FSM SHALL have three states: REQ, ISSUE, FAULT.
REQ-019 REQ: mem_req=1 and mem_addr=pc; on mem_ack the block SHALL latch mem_rdata into instruction and enter ISSUE, so instr_valid rises the cycle after the ack.
REQ-020 REQ: a wait counter SHALL clear on entry; if it reaches TIMEOUT without mem_ack, the block SHALL enter FAULT with fault_pc=pc.
REQ-021 ISSUE: instr_valid=1, mem_req=0; instruction and pc SHALL hold stable until advance.
REQ-022 Advance SHALL occur in ISSUE when instr_done=1 and stall=0, with next PC selected by PC_sel:
- 00: pc+4
- 01: branch_target
- 10: {jalr_target[31:1],1'b0}
- 11: hold
REQ-023 PC_sel=11 at advance SHALL keep the state in ISSUE with pc and instruction unchanged.
REQ-024 If the next PC has bits [1:0]≠0, the block SHALL enter FAULT with fault_pc=next PC and pc unchanged; otherwise it SHALL set pc=next PC and enter REQ.
REQ-025 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000 without fault.
REQ-026 mem_ack outside REQ SHALL be ignored.
REQ-027 instr_done outside ISSUE SHALL be ignored.
REQ-028 stall=1 with instr_done=1 SHALL take priority and block the advance.
REQ-029 FAULT SHALL hold mem_req=0, instr_valid=0, fault=1 until reset.
REQ-030 When instr_valid=0, instruction SHALL retain its last value.

Reset
REQ-031 Reset asserted SHALL immediately set:
- state=REQ
- pc=RESET_PC
- instruction=32'h0000_0013 (NOP)
- instr_valid=0
- fault=0
- fault_pc=0
- wait counter=0
REQ-032 mem_req SHALL be 0 while reset is low, including when reset asserts mid-request.
REQ-033 mem_req SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-034 The PC_sel encodings, FSM state codes, the NOP constant and the RESET_PC default SHALL live in a shared package, fetch_defs, also used by UnidadDeControl.
REQ-035 Next-PC selection and alignment check SHALL be a combinational sub-module, next_pc_calc, with inputs pc, PC_sel and the targets, and outputs next_pc and misaligned.

Verification
REQ-036 Reset release, memory acking after 3 cycles with 32'h0050_0093 -> mem_addr=0, instr_valid high on the cycle after the ack, instruction=32'h0050_0093.
REQ-037 pc=0x10: PC_sel=00, instr_done -> next mem_addr=0x14; PC_sel=01, branch_target=0x40 -> mem_addr=0x40; PC_sel=10, jalr_target=0x81 -> mem_addr=0x80.
REQ-038 stall=1 with instr_done=1 for 4 cycles -> pc and instruction unchanged, no mem_req; stall drops -> advance on that edge.
REQ-039 branch_target=0x42 at advance -> fault=1, fault_pc=0x42, pc unchanged, mem_req stays 0 until reset.
REQ-040 No mem_ack for TIMEOUT=8 cycles -> fault=1, fault_pc=pc.
REQ-041 Reset low mid-request -> mem_req=0 same cycle; after release, pc=RESET_PC.
